// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, PC-select codes and forwarding helper for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ      = 2'd0;
  localparam logic [1:0] PC_SEL_REDIRECT = 2'd1;
  localparam logic [1:0] PC_SEL_HOLD     = 2'd2;
  localparam logic [1:0] PC_SEL_RESET    = 2'd3;

  // True when the S3 writer targets a register the S2 instruction actually reads; x0 never matches.
  function automatic logic fwd_hit(input logic [4:0] rd, input logic [4:0] rs, input logic rs_used);
    return rs_used && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// rtl/pipe_ctrl_perf.sv - cycle / retired-instruction / redirect counters for pipe_ctrl
module pipe_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             perf_clr,
  input  logic             cycle_inc,
  input  logic             instret_inc,
  input  logic             redirect_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  // Free-running wrap-around counters; a clear beats any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
      redirect_cnt <= '0;
    end else if (perf_clr) begin
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
      redirect_cnt <= '0;
    end else begin
      if (cycle_inc)    cycle_cnt    <= cycle_cnt + 1'b1;
      if (instret_inc)  instret_cnt  <= instret_cnt + 1'b1;
      if (redirect_inc) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 3-stage pipeline sequencer (boot hold, redirect flush, memory freeze, forwarding); PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s2_valid,
  input  logic [4:0]       s2_rs1,
  input  logic [4:0]       s2_rs2,
  input  logic             s2_rs1_used,
  input  logic             s2_rs2_used,
  input  logic             s3_valid,
  input  logic [4:0]       s3_rd,
  input  logic             s3_reg_we,
  input  logic             s3_redirect,
  input  logic             s3_mem_req,
  input  logic             s3_mem_ready,
  input  logic             perf_clr,
  output logic [1:0]       pc_sel,
  output logic             stall_all,
  output logic             s1_flush,
  output logic             s2_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       redirect_acc;

  // State and boot-hold counter; reset always restarts the boot hold from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      hold_q  <= HOLD_INIT;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and PC/stall/flush steering; everything is qualified by s3_valid.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pc_sel       = PC_SEL_SEQ;
    stall_all    = 1'b0;
    s1_flush     = 1'b0;
    s2_flush     = 1'b0;
    redirect_acc = 1'b0;
    case (state_q)
      BOOT: begin
        pc_sel   = PC_SEL_RESET;
        s1_flush = 1'b1;
        s2_flush = 1'b1;
        if (hold_q == 4'd0) state_d = RUN;
        else                hold_d  = hold_q - 4'd1;
      end
      RUN: begin
        // A taken redirect wins; a memory request in the same cycle belongs to a squashed path.
        if (s3_valid && s3_redirect) begin
          pc_sel       = PC_SEL_REDIRECT;
          s1_flush     = 1'b1;
          s2_flush     = 1'b1;
          redirect_acc = 1'b1;
        end else if (s3_valid && s3_mem_req && !s3_mem_ready) begin
          pc_sel    = PC_SEL_HOLD;
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // The ready cycle releases the freeze so every stage advances together.
        if (s3_valid && s3_mem_ready) begin
          state_d = RUN;
        end else begin
          pc_sel    = PC_SEL_HOLD;
          stall_all = 1'b1;
        end
      end
      default: begin
        state_d  = BOOT;
        hold_d   = HOLD_INIT;
        pc_sel   = PC_SEL_RESET;
        s1_flush = 1'b1;
        s2_flush = 1'b1;
      end
    endcase
  end

  // Forwarding is held off during reset so the operand muxes see a clean default.
  assign fwd_a = !rst && s3_valid && s3_reg_we && s2_valid && fwd_hit(s3_rd, s2_rs1, s2_rs1_used);
  assign fwd_b = !rst && s3_valid && s3_reg_we && s2_valid && fwd_hit(s3_rd, s2_rs2, s2_rs2_used);

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .perf_clr     (perf_clr),
    .cycle_inc    (state_q != BOOT),
    .instret_inc  (s3_valid && !stall_all),
    .redirect_inc (redirect_acc),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt),
    .redirect_cnt (redirect_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf  = perf_clr | redirect_acc;
  assign cycle_cnt    = '0;
  assign instret_cnt  = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencing controller for the 3-stage RV32I core (S1 fetch/decode, S2 execute, S3 memory/writeback). It owns the PC-select policy, including the boot hold after reset, redirect-taken flushes, and freezing the whole pipe during multi-cycle S3 memory accesses. It also generates the S3→S2 writeback forwarding selects. The per-stage decode blocks drive its inputs; its outputs steer the PC mux, the pipeline-register enables and bubble inserts, and the S2 operand muxes.

## Interface
- RESET_HOLD_CYCLES, 2: cycles pc_sel is held at the reset vector after rst deasserts (range 1–15).
- CNT_W, 32: width of each performance counter.
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- s2_valid  in  1  S2 holds a real (non-bubble) instruction.
- s2_rs1, s2_rs2  in  5 each  S2 source register indices.
- s2_rs1_used, s2_rs2_used  in  1 each  the S2 instruction reads rs1 or rs2.
- s3_valid  in  1  S3 holds a real instruction.
- s3_rd  in  5  S3 destination register.
- s3_reg_we  in  1  the S3 instruction writes the register file.
- s3_redirect  in  1  branch taken or jal/jalr resolved in S3.
- s3_mem_req  in  1  the S3 instruction accesses memory or MMIO this cycle.
- s3_mem_ready  in  1  the memory access completes this cycle.
- perf_clr  in  1  synchronous clear of all counters.
- pc_sel  out  2  0 = PC+4, 1 = redirect target, 2 = hold, 3 = reset vector.
- stall_all  out  1  holds the PC and all pipeline registers.
- s1_flush, s2_flush  out  1 each  insert a NOP into the S1→S2 or S2→S3 register.
- fwd_a, fwd_b  out  1 each  S2 operand A/B takes S3 writeback data.
- cycle_cnt, instret_cnt, redirect_cnt  out  CNT_W each  performance counters.

## Operation
- The FSM has three states: BOOT, RUN and MEM_WAIT.
- BOOT:
  - The state entered on reset.
  - A hold counter loads RESET_HOLD_CYCLES−1 and decrements each cycle.
  - Outputs: pc_sel=3, s1_flush=s2_flush=1, stall_all=0.
  - Moves to RUN when the counter reaches 0.
- RUN:
  - If s3_valid & s3_redirect: pc_sel=1, s1_flush=s2_flush=1.
  - Else if s3_valid & s3_mem_req & !s3_mem_ready: stall_all=1, pc_sel=2, next state MEM_WAIT.
  - Else: pc_sel=0.
  - Redirect has priority over a memory request in the same cycle; the memory request is then ignored.
- MEM_WAIT:
  - Outputs: stall_all=1, pc_sel=2, no flushes.
  - On s3_mem_ready: stall_all=0, pc_sel=0, next state RUN.
  - On the ready cycle, all pipeline registers advance together.
- Forwarding (all states):
  - fwd_a = s3_valid & s3_reg_we & (s3_rd≠0) & s2_valid & s2_rs1_used & (s3_rd==s2_rs1).
  - fwd_b is the same with s2_rs2 and s2_rs2_used.
  - Register x0 is never forwarded.
  - No load-use stall exists: the S3 writeback data is the forwarded source.
- All inputs are ignored while s3_valid=0.

## Timing
- State and hold counter are registered.
- All outputs are combinational from the state and the current inputs.
- Values while rst is high: state=BOOT, pc_sel=3, s1_flush=s2_flush=1, stall_all=0, fwd_a=fwd_b=0, all counters 0.
- Redirect costs 2 bubbles: the flush takes effect in the same cycle as the redirect.
- Memory stall lasts exactly the number of cycles s3_mem_ready stays low after the request.
- If s3_mem_ready is high in the same cycle as the request, there is no stall.
- rst asserted mid-MEM_WAIT or mid-BOOT returns the FSM to BOOT immediately and restarts the hold count.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - cycle_cnt increments every cycle not in BOOT.
  - instret_cnt increments when s3_valid & !stall_all.
  - redirect_cnt increments on each accepted redirect.
  - perf_clr zeroes all three counters and takes priority over increment.
  - Counters wrap modulo 2^CNT_W.
- PIPE_CTRL_PERF_EN undefined:
  - The counter ports remain and are tied to 0.
  - perf_clr is ignored.
  - No counter flops are present.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (BOOT, RUN, MEM_WAIT);
  - the PC_SEL_SEQ/REDIRECT/HOLD/RESET constants (0–3).
- One sub-module, pipe_ctrl_perf, holds the three counters and is instantiated only under PIPE_CTRL_PERF_EN.

## Test plan
- Boot: release rst → pc_sel=3 with both flushes high for exactly 2 cycles, then pc_sel=0 and cycle_cnt begins at 1.
- Redirect: s3_valid=1, s3_redirect=1 for one cycle → pc_sel=1, s1_flush=s2_flush=1 that cycle only; redirect_cnt +1.
- Memory wait: s3_mem_req=1 with ready low for 3 cycles, then high → stall_all high for 3 cycles, pc_sel=2, then RUN; instret_cnt +1 only on the ready cycle.
- Forwarding: s3_rd=5, s3_reg_we=1, s2_rs1=5, s2_rs2=5, both used → fwd_a=fwd_b=1. Repeat with s3_rd=0 → both 0. Repeat with s3_valid=0 → both 0.
- Priority: s3_redirect=1 and s3_mem_req=1 with ready low → pc_sel=1, stall_all=0, state stays RUN.
- Reset mid-stall: assert rst during MEM_WAIT → outputs take their reset values immediately; after release, the boot sequence repeats.
